mure_serializer: RTL and testbench
==================================

Name: mure_serializer

Overview:
- Sits between the CPU commit ports and `multiple_retire`/trace encoder.
- Accepts a bundle of up to NrRetiredInstr retired instructions per cycle, plus at most one exception/interrupt and eret per bundle.
- Buffers bundles in an ingress FIFO and replays them as one instruction per cycle, honouring a downstream ready.
- The CPU commit path cannot stall, so overflow is flagged, never back-pressured.

Parameters:
- NrRetiredInstr, 2, commit ports per cycle (>=1).
- FifoDepth, 8, bundle FIFO entries (power of two, >=2).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  synchronous flush of FIFO, slot index and output register
- valids_i  in  NrRetiredInstr  per-slot retire valid; contiguous from slot 0
- uops_i  in  NrRetiredInstr*INST_LEN  per-slot instruction word, slot 0 in LSBs
- pcs_i  in  NrRetiredInstr*XLEN  per-slot PC
- exception_i  in  1  exception/interrupt attached to this bundle
- eret_i  in  1  last valid slot is xRET
- cause_i  in  CAUSE_LEN  trap cause (already privilege-selected)
- tval_i  in  XLEN  trap value
- priv_lvl_i  in  PRIV_LEN  privilege at commit
- out_ready_i  in  1  downstream accepts current beat
- inst_valid_o  out  1  beat valid
- iretired_o  out  1  beat is a retired instruction
- exception_o  out  1  beat carries trap
- interrupt_o  out  1  trap is interrupt (cause MSB)
- eret_o  out  1  beat is xRET
- inst_data_o  out  INST_LEN  instruction word
- pc_o  out  XLEN  instruction address
- epc_o  out  XLEN  trapping PC
- cause_o  out  CAUSE_LEN  trap cause
- tval_o  out  XLEN  trap value
- priv_lvl_o  out  PRIV_LEN  privilege
- overflow_o  out  1  sticky: a bundle was dropped

Behaviour:
- Reset: all outputs 0, FIFO empty, slot index 0, overflow_o 0.
- Push condition: `(|valids_i) || exception_i`. Bundles with no valid slot and no exception are ignored.
- Push while FIFO full:
  - Bundle is dropped and overflow_o sets; it stays set until reset or flush_i.
  - Push and pop in the same cycle while full is legal (fifo_v3 semantics): a simultaneous pop frees the slot, so no overflow.
- Beat count per bundle:
  - `popcount(valids)` beats.
  - An exception with `valids==0` (interrupt with no retirement) yields exactly one beat: iretired_o=0, exception_o=1, pc_o=epc_o=slot-0 PC.
- Trap placement:
  - exception_i attaches to the last valid slot. That beat has exception_o=1, interrupt_o=cause_i[CAUSE_LEN-1], epc_o=its PC, and cause_o/tval_o set.
  - If the trap is an exception (not an interrupt), that beat has iretired_o=0.
  - All other beats have iretired_o=1 and cause_o/tval_o/epc_o = 0.
  - eret_o is set only on the last valid beat.
- Output register:
  - Loads the head-bundle slot at the current index when FIFO non-empty and (`!inst_valid_o || out_ready_i`).
  - Holds all fields stable while `inst_valid_o && !out_ready_i`.
  - Clears inst_valid_o when ready and nothing is available.
- Slot index:
  - Increments per load.
  - On the last beat of a bundle: FIFO pops, index returns to 0.
  - Throughput is 1 beat/cycle with no bubble between bundles.
- Latency: bundle presented in cycle t gives its first beat on outputs at t+2 when the FIFO was empty and ready is held.
- flush_i:
  - Takes effect next edge: FIFO emptied, index 0, inst_valid_o 0, overflow_o 0.
  - An input bundle in the same cycle is discarded.
- Reset mid-bundle discards remaining beats.
- Assertions: valids_i contiguous; no X on outputs when inst_valid_o.

Decomposition:
- mure_pkg holds:
  - XLEN, INST_LEN, CAUSE_LEN, PRIV_LEN.
  - typedef `bundle_entry_s`: valids, uops, pcs, exception, eret, cause, tval, priv.
  - typedef `beat_s` for the output register.
- Sub-module: `fifo_v3` (common_cells) with dtype `bundle_entry_s`.
- Beat selection, last-valid-slot detection and popcount stay in this module.

Test Plan (N=2, FifoDepth=4):
- Single bundle: valids=2'b11, PCs 0x80000000/0x80000004, ready=1 → beats at t+2 and t+3 with those PCs, iretired_o=1, no trap.
- Exception on slot 1: valids=2'b11, exception_i=1, cause=2, tval=0xDEAD → beat 0 normal; beat 1 exception_o=1, iretired_o=0, interrupt_o=0, epc_o=0x80000004, cause_o=2.
- Interrupt, no retire: valids=0, exception_i=1, cause MSB=1, slot-0 PC 0x100 → one beat: iretired_o=0, interrupt_o=1, epc_o=pc_o=0x100.
- Backpressure: out_ready_i=0 for 10 cycles while pushing full bundles → outputs stable; 5th bundle sets overflow_o; after release the first 4 bundles drain in order, 8 beats back-to-back.
- flush_i mid-bundle after beat 0 of 2 → next cycle inst_valid_o=0, overflow_o=0; following bundle emits from slot 0.
- Async reset mid-drain → outputs 0 immediately; FIFO empty after deassert.

Source files
------------

// File: rtl/mure_pkg.sv
// Shared widths and data types for the retire-bundle serializer.
package mure_pkg;

    localparam int unsigned XLEN             = 64;
    localparam int unsigned INST_LEN         = 32;
    localparam int unsigned CAUSE_LEN        = 64;
    localparam int unsigned PRIV_LEN         = 2;
    localparam int unsigned NR_RETIRED_INSTR = 2;
    localparam int unsigned CNT_W            = $clog2(NR_RETIRED_INSTR + 1);

    // One commit-port bundle as stored in the ingress FIFO.
    typedef struct packed {
        logic [NR_RETIRED_INSTR-1:0]               valids;
        logic [NR_RETIRED_INSTR-1:0][INST_LEN-1:0] uops;
        logic [NR_RETIRED_INSTR-1:0][XLEN-1:0]     pcs;
        logic                                      exception;
        logic                                      eret;
        logic [CAUSE_LEN-1:0]                      cause;
        logic [XLEN-1:0]                           tval;
        logic [PRIV_LEN-1:0]                       priv;
    } bundle_entry_s;

    // One serialized beat as held in the output register.
    typedef struct packed {
        logic                 iretired;
        logic                 exception;
        logic                 interrupt;
        logic                 eret;
        logic [INST_LEN-1:0]  inst;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      epc;
        logic [CAUSE_LEN-1:0] cause;
        logic [XLEN-1:0]      tval;
        logic [PRIV_LEN-1:0]  priv;
    } beat_s;

    // Number of set bits in a slot-valid vector.
    function automatic logic [CNT_W-1:0] popcount(input logic [NR_RETIRED_INSTR-1:0] v);
        logic [CNT_W-1:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < NR_RETIRED_INSTR; i++) begin
            if (v[i]) cnt = cnt + CNT_W'(1);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mure_serializer_if.sv
// Commit-side bundle inputs and trace-side beat outputs of the serializer.
interface mure_serializer_if;
    import mure_pkg::*;

    logic [NR_RETIRED_INSTR-1:0]          valids_i;
    logic [NR_RETIRED_INSTR*INST_LEN-1:0] uops_i;
    logic [NR_RETIRED_INSTR*XLEN-1:0]     pcs_i;
    logic                                 exception_i;
    logic                                 eret_i;
    logic [CAUSE_LEN-1:0]                 cause_i;
    logic [XLEN-1:0]                      tval_i;
    logic [PRIV_LEN-1:0]                  priv_lvl_i;
    logic                                 out_ready_i;

    logic                                 inst_valid_o;
    logic                                 iretired_o;
    logic                                 exception_o;
    logic                                 interrupt_o;
    logic                                 eret_o;
    logic [INST_LEN-1:0]                  inst_data_o;
    logic [XLEN-1:0]                      pc_o;
    logic [XLEN-1:0]                      epc_o;
    logic [CAUSE_LEN-1:0]                 cause_o;
    logic [XLEN-1:0]                      tval_o;
    logic [PRIV_LEN-1:0]                  priv_lvl_o;
    logic                                 overflow_o;

    // CPU commit side plus trace consumer.
    modport master (
        output valids_i, uops_i, pcs_i, exception_i, eret_i, cause_i, tval_i, priv_lvl_i,
        output out_ready_i,
        input  inst_valid_o, iretired_o, exception_o, interrupt_o, eret_o, inst_data_o,
        input  pc_o, epc_o, cause_o, tval_o, priv_lvl_o, overflow_o
    );

    // The serializer itself.
    modport slave (
        input  valids_i, uops_i, pcs_i, exception_i, eret_i, cause_i, tval_i, priv_lvl_i,
        input  out_ready_i,
        output inst_valid_o, iretired_o, exception_o, interrupt_o, eret_o, inst_data_o,
        output pc_o, epc_o, cause_o, tval_o, priv_lvl_o, overflow_o
    );

endinterface

// File: rtl/fifo_v3.sv
// Small synchronous FIFO; a push while full is accepted when a pop happens in the same cycle.
module fifo_v3 #(
    parameter int unsigned DEPTH = 8,
    parameter type         dtype = logic
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic flush_i,
    input  logic push_i,
    input  dtype data_i,
    input  logic pop_i,
    output dtype data_o,
    output logic full_o,
    output logic empty_o
);

    localparam int unsigned AddrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    dtype             mem_q [DEPTH];
    logic [AddrW-1:0] rd_ptr_q;
    logic [AddrW-1:0] wr_ptr_q;
    logic [AddrW:0]   count_q;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == (AddrW + 1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);
    assign data_o  = mem_q[rd_ptr_q];

    // Pointer and occupancy bookkeeping; flush empties the queue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AddrW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AddrW'(1);
            if (push_ok && !pop_ok)      count_q <= count_q + (AddrW + 1)'(1);
            else if (pop_ok && !push_ok) count_q <= count_q - (AddrW + 1)'(1);
        end
    end

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/mure_serializer.sv
// Buffers multi-instruction retire bundles and replays them one instruction per cycle.
module mure_serializer
    import mure_pkg::*;
#(
    parameter int unsigned NrRetiredInstr = NR_RETIRED_INSTR,
    parameter int unsigned FifoDepth      = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    mure_serializer_if.slave bus
);

    localparam int unsigned IdxW = (NrRetiredInstr > 1) ? $clog2(NrRetiredInstr) : 1;

    // Bundle layout is fixed by the package, so the slot count must agree with it.
    if (NrRetiredInstr != NR_RETIRED_INSTR) begin : g_nr_check
        $error("NrRetiredInstr must equal mure_pkg::NR_RETIRED_INSTR");
    end

    bundle_entry_s in_bundle;
    bundle_entry_s head;
    logic          push_req;
    logic          fifo_pop;
    logic          fifo_full;
    logic          fifo_empty;

    logic [CNT_W-1:0] nr_valid;
    logic [IdxW-1:0]  last_idx;
    logic [IdxW-1:0]  idx_q;
    logic             is_last;
    logic             load;
    logic             trap_here;
    beat_s            beat_d;
    beat_s            beat_q;
    logic             valid_q;
    logic             overflow_q;

    // Pack commit-port signals into one FIFO entry.
    always_comb begin
        in_bundle           = '0;
        in_bundle.valids    = bus.valids_i;
        in_bundle.uops      = bus.uops_i;
        in_bundle.pcs       = bus.pcs_i;
        in_bundle.exception = bus.exception_i;
        in_bundle.eret      = bus.eret_i;
        in_bundle.cause     = bus.cause_i;
        in_bundle.tval      = bus.tval_i;
        in_bundle.priv      = bus.priv_lvl_i;
    end

    assign push_req = ((|bus.valids_i) || bus.exception_i) && !flush_i;

    fifo_v3 #(
        .DEPTH (FifoDepth),
        .dtype (bundle_entry_s)
    ) i_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .flush_i (flush_i),
        .push_i  (push_req),
        .data_i  (in_bundle),
        .pop_i   (fifo_pop),
        .data_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // Select the head-bundle slot at the current index and place the trap on its last valid slot.
    always_comb begin
        nr_valid  = popcount(head.valids);
        last_idx  = (nr_valid == '0) ? '0 : IdxW'(nr_valid - CNT_W'(1));
        is_last   = (idx_q == last_idx);
        load      = !fifo_empty && (!valid_q || bus.out_ready_i);
        fifo_pop  = load && is_last;
        trap_here = head.exception && is_last;

        beat_d           = '0;
        beat_d.inst      = head.uops[idx_q];
        beat_d.pc        = head.pcs[idx_q];
        beat_d.priv      = head.priv;
        beat_d.exception = trap_here;
        beat_d.interrupt = trap_here && head.cause[CAUSE_LEN-1];
        beat_d.iretired  = (nr_valid != '0) && !(trap_here && !head.cause[CAUSE_LEN-1]);
        beat_d.eret      = head.eret && is_last;
        if (trap_here) begin
            beat_d.epc   = head.pcs[idx_q];
            beat_d.cause = head.cause;
            beat_d.tval  = head.tval;
        end
    end

    // Output register: load on free/consumed slot, hold under back-pressure.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end else if (load) begin
            valid_q <= 1'b1;
            beat_q  <= beat_d;
        end else if (bus.out_ready_i) begin
            valid_q <= 1'b0;
            beat_q  <= '0;
        end
    end

    // Slot index within the head bundle; wraps to 0 when the bundle pops.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            idx_q <= '0;
        end else if (flush_i) begin
            idx_q <= '0;
        end else if (load) begin
            idx_q <= is_last ? '0 : idx_q + IdxW'(1);
        end
    end

    // Sticky drop flag; a pop in the same cycle frees the slot so no drop occurs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            overflow_q <= 1'b0;
        end else if (flush_i) begin
            overflow_q <= 1'b0;
        end else if (push_req && fifo_full && !fifo_pop) begin
            overflow_q <= 1'b1;
        end
    end

    assign bus.inst_valid_o = valid_q;
    assign bus.iretired_o   = beat_q.iretired;
    assign bus.exception_o  = beat_q.exception;
    assign bus.interrupt_o  = beat_q.interrupt;
    assign bus.eret_o       = beat_q.eret;
    assign bus.inst_data_o  = beat_q.inst;
    assign bus.pc_o         = beat_q.pc;
    assign bus.epc_o        = beat_q.epc;
    assign bus.cause_o      = beat_q.cause;
    assign bus.tval_o       = beat_q.tval;
    assign bus.priv_lvl_o   = beat_q.priv;
    assign bus.overflow_o   = overflow_q;

    logic [NrRetiredInstr-1:0] valids_inc;
    assign valids_inc = bus.valids_i + NrRetiredInstr'(1);

    a_valids_contiguous: assert property (@(posedge clk_i) disable iff (!rst_ni)
        ((bus.valids_i & valids_inc) == '0));

    a_no_x_when_valid: assert property (@(posedge clk_i) disable iff (!rst_ni)
        valid_q |-> !$isunknown(beat_q));

endmodule

// File: tb/tb_mure_serializer.sv
// Scoreboard bench for mure_serializer with two commit ports and a four-entry FIFO.
module tb_mure_serializer;
    import mure_pkg::*;

    localparam int unsigned FIFO_DEPTH = 4;

    logic clk;
    logic rst_n;
    logic flush;

    mure_serializer_if bus ();

    mure_serializer #(
        .NrRetiredInstr (NR_RETIRED_INSTR),
        .FifoDepth      (FIFO_DEPTH)
    ) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (flush),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned         total;
    int unsigned         bad;
    beat_s               exp_q [$];
    beat_s               got;
    beat_s               want;
    beat_s               snap;
    logic [PRIV_LEN-1:0] cur_priv;

    function automatic beat_s observed();
        beat_s b;
        b.iretired  = bus.iretired_o;
        b.exception = bus.exception_o;
        b.interrupt = bus.interrupt_o;
        b.eret      = bus.eret_o;
        b.inst      = bus.inst_data_o;
        b.pc        = bus.pc_o;
        b.epc       = bus.epc_o;
        b.cause     = bus.cause_o;
        b.tval      = bus.tval_o;
        b.priv      = bus.priv_lvl_o;
        return b;
    endfunction

    // Reference expansion of one bundle into its expected beats.
    function automatic void model_push(input logic [1:0] valids, input logic [XLEN-1:0] pc0,
                                       input logic [XLEN-1:0] pc1, input logic [INST_LEN-1:0] u0,
                                       input logic [INST_LEN-1:0] u1, input logic exc, input logic eret,
                                       input logic [CAUSE_LEN-1:0] cause, input logic [XLEN-1:0] tval,
                                       input logic [PRIV_LEN-1:0] priv);
        int n;
        beat_s b;
        logic [XLEN-1:0] pcs [2];
        logic [INST_LEN-1:0] us [2];
        pcs[0] = pc0; pcs[1] = pc1; us[0] = u0; us[1] = u1;
        n = int'(valids[0]) + int'(valids[1]);
        if (n == 0) begin
            if (!exc) return;
            b = '0;
            b.exception = 1'b1;
            b.interrupt = cause[CAUSE_LEN-1];
            b.eret = eret;
            b.inst = u0; b.pc = pc0; b.epc = pc0;
            b.cause = cause; b.tval = tval; b.priv = priv;
            exp_q.push_back(b);
            return;
        end
        for (int i = 0; i < n; i++) begin
            b = '0;
            b.inst = us[i]; b.pc = pcs[i]; b.priv = priv;
            b.iretired = 1'b1;
            if (i == n - 1) begin
                b.eret = eret;
                if (exc) begin
                    b.exception = 1'b1;
                    b.interrupt = cause[CAUSE_LEN-1];
                    b.iretired = cause[CAUSE_LEN-1];
                    b.epc = pcs[i]; b.cause = cause; b.tval = tval;
                end
            end
            exp_q.push_back(b);
        end
    endfunction

    task automatic idle();
        bus.valids_i = '0; bus.uops_i = '0; bus.pcs_i = '0;
        bus.exception_i = 1'b0; bus.eret_i = 1'b0;
        bus.cause_i = '0; bus.tval_i = '0; bus.priv_lvl_i = cur_priv;
    endtask

    task automatic drive(input logic [1:0] valids, input logic [XLEN-1:0] pc0, input logic [XLEN-1:0] pc1,
                         input logic exc, input logic eret, input logic [CAUSE_LEN-1:0] cause,
                         input logic [XLEN-1:0] tval, input bit keep);
        logic [INST_LEN-1:0] u0, u1;
        u0 = pc0[INST_LEN-1:0] ^ 32'h0000_0013;
        u1 = pc1[INST_LEN-1:0] ^ 32'h0000_0093;
        bus.valids_i = valids; bus.uops_i = {u1, u0}; bus.pcs_i = {pc1, pc0};
        bus.exception_i = exc; bus.eret_i = eret;
        bus.cause_i = cause; bus.tval_i = tval; bus.priv_lvl_i = cur_priv;
        if (keep) model_push(valids, pc0, pc1, u0, u1, exc, eret, cause, tval, cur_priv);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; bus.out_ready_i = 1'b0; cur_priv = 2'b11; idle();
        repeat (3) @(negedge clk);
        total++;
        if (observed() !== '0) begin bad++; $display("FAIL reset_fields got=%h want=0", observed()); end
        total++;
        if ({bus.inst_valid_o, bus.overflow_o} !== 2'b00) begin
            bad++; $display("FAIL reset_flags got=%b want=00", {bus.inst_valid_o, bus.overflow_o});
        end
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL reset_after got=%b want=0", bus.inst_valid_o); end
        bus.out_ready_i = 1'b1;
    endtask

    task automatic test_single();
        drive(2'b11, 64'h8000_0000, 64'h8000_0004, 1'b0, 1'b0, '0, '0, 1'b1);
        @(negedge clk); idle();
        total++;
        if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL single_early got=%b want=0", bus.inst_valid_o); end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            total++;
            if (bus.inst_valid_o !== 1'b1) begin bad++; $display("FAIL single_valid%0d got=%b want=1", k, bus.inst_valid_o); end
            got = observed(); want = exp_q.pop_front();
            total++;
            if (got !== want) begin bad++; $display("FAIL single_beat%0d got=%h want=%h", k, got, want); end
        end
        @(negedge clk);
        total++;
        if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL single_idle got=%b want=0", bus.inst_valid_o); end
    endtask

    task automatic test_exception();
        drive(2'b11, 64'h8000_0000, 64'h8000_0004, 1'b1, 1'b0, 64'd2, 64'hDEAD, 1'b1);
        @(negedge clk); idle();
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            if (bus.inst_valid_o && bus.out_ready_i) begin
                got = observed(); want = exp_q.pop_front(); total++;
                if (got !== want) begin bad++; $display("FAIL exc_beat got=%h want=%h", got, want); end
            end
            @(negedge clk); idle();
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL exc_drain left=%0d want=0", exp_q.size()); exp_q.delete(); end
    endtask

    task automatic test_interrupt();
        drive(2'b00, 64'h100, 64'h104, 1'b1, 1'b0, {1'b1, 63'd7}, 64'h0, 1'b1);
        @(negedge clk); idle();
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            if (bus.inst_valid_o && bus.out_ready_i) begin
                got = observed(); want = exp_q.pop_front(); total++;
                if (got !== want) begin bad++; $display("FAIL irq_beat got=%h want=%h", got, want); end
            end
            @(negedge clk); idle();
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL irq_drain left=%0d want=0", exp_q.size()); exp_q.delete(); end
        total++;
        if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL irq_single got=%b want=0", bus.inst_valid_o); end
    endtask

    task automatic test_back_to_back();
        bit started;
        cur_priv = 2'b01;
        started = 1'b0;
        drive(2'b11, 64'h1000, 64'h1004, 1'b0, 1'b1, '0, '0, 1'b1);
        @(negedge clk);
        drive(2'b11, 64'h1010, 64'h1014, 1'b1, 1'b0, {1'b1, 63'd11}, 64'h55, 1'b1);
        @(negedge clk); idle();
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            if (started) begin
                total++;
                if (bus.inst_valid_o !== 1'b1) begin bad++; $display("FAIL b2b_gap got=%b want=1", bus.inst_valid_o); end
            end
            if (bus.inst_valid_o && bus.out_ready_i) begin
                started = 1'b1;
                got = observed(); want = exp_q.pop_front(); total++;
                if (got !== want) begin bad++; $display("FAIL b2b_beat got=%h want=%h", got, want); end
            end
            @(negedge clk); idle();
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL b2b_drain left=%0d want=0", exp_q.size()); exp_q.delete(); end
        cur_priv = 2'b11;
    endtask

    task automatic test_backpressure();
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(2'b11, 64'h4000 + 64'(16 * i), 64'h4004 + 64'(16 * i), 1'b0, 1'b0, '0, '0, i < 4);
            @(negedge clk);
        end
        idle();
        snap = observed();
        total++;
        if (bus.inst_valid_o !== 1'b1) begin bad++; $display("FAIL bp_loaded got=%b want=1", bus.inst_valid_o); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (observed() !== snap || bus.inst_valid_o !== 1'b1) begin
                bad++; $display("FAIL bp_hold got=%h want=%h", observed(), snap);
            end
        end
        total++;
        if (bus.overflow_o !== 1'b1) begin bad++; $display("FAIL bp_overflow got=%b want=1", bus.overflow_o); end
        bus.out_ready_i = 1'b1;
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
            total++;
            if (bus.inst_valid_o !== 1'b1) begin bad++; $display("FAIL bp_gap got=%b want=1", bus.inst_valid_o); end
            if (bus.inst_valid_o) begin
                got = observed(); want = exp_q.pop_front(); total++;
                if (got !== want) begin bad++; $display("FAIL bp_beat got=%h want=%h", got, want); end
            end
            @(negedge clk); idle();
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL bp_drain left=%0d want=0", exp_q.size()); exp_q.delete(); end
        total++;
        if (bus.overflow_o !== 1'b1) begin bad++; $display("FAIL bp_sticky got=%b want=1", bus.overflow_o); end
    endtask

    task automatic test_flush();
        drive(2'b11, 64'h2000, 64'h2004, 1'b0, 1'b0, '0, '0, 1'b1);
        @(negedge clk); idle();
        @(negedge clk);
        got = observed(); want = exp_q.pop_front(); total++;
        if (got !== want || bus.inst_valid_o !== 1'b1) begin bad++; $display("FAIL flush_beat0 got=%h want=%h", got, want); end
        exp_q.delete();
        flush = 1'b1;
        drive(2'b11, 64'h2100, 64'h2104, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        flush = 1'b0; idle();
        total++;
        if ({bus.inst_valid_o, bus.overflow_o} !== 2'b00) begin
            bad++; $display("FAIL flush_clear got=%b want=00", {bus.inst_valid_o, bus.overflow_o});
        end
        @(negedge clk);
        drive(2'b11, 64'h3000, 64'h3004, 1'b0, 1'b0, '0, '0, 1'b1);
        @(negedge clk); idle();
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) begin
            if (bus.inst_valid_o && bus.out_ready_i) begin
                got = observed(); want = exp_q.pop_front(); total++;
                if (got !== want) begin bad++; $display("FAIL flush_next got=%h want=%h", got, want); end
            end
            @(negedge clk); idle();
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL flush_drain left=%0d want=0", exp_q.size()); exp_q.delete(); end
        repeat (3) @(negedge clk);
        total++;
        if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL flush_leak got=%b want=0", bus.inst_valid_o); end
    endtask

    task automatic test_full_push_pop();
        bus.out_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            drive(2'b01, 64'h5000 + 64'(16 * i), 64'h0, i == 3, i == 2, (i == 3) ? 64'd5 : 64'd0,
                  (i == 3) ? 64'hBEEF : 64'h0, 1'b1);
            @(negedge clk);
        end
        total++;
        if (bus.overflow_o !== 1'b0) begin bad++; $display("FAIL full_pre got=%b want=0", bus.overflow_o); end
        bus.out_ready_i = 1'b1;
        drive(2'b01, 64'h5050, 64'h0, 1'b0, 1'b0, '0, '0, 1'b1);
        for (int c = 0; c < 30 && exp_q.size() != 0; c++) begin
            if (bus.inst_valid_o && bus.out_ready_i) begin
                got = observed(); want = exp_q.pop_front(); total++;
                if (got !== want) begin bad++; $display("FAIL full_beat got=%h want=%h", got, want); end
            end
            @(negedge clk); idle();
        end
        total++;
        if (exp_q.size() != 0) begin bad++; $display("FAIL full_drain left=%0d want=0", exp_q.size()); exp_q.delete(); end
        total++;
        if (bus.overflow_o !== 1'b0) begin bad++; $display("FAIL full_overflow got=%b want=0", bus.overflow_o); end
    endtask

    task automatic test_reset_mid();
        drive(2'b11, 64'h6000, 64'h6004, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        drive(2'b11, 64'h6010, 64'h6014, 1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk); idle();
        total++;
        if (bus.inst_valid_o !== 1'b1) begin bad++; $display("FAIL rmid_active got=%b want=1", bus.inst_valid_o); end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (observed() !== '0 || bus.inst_valid_o !== 1'b0) begin
            bad++; $display("FAIL rmid_async got=%h valid=%b want=0", observed(), bus.inst_valid_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            total++;
            if (bus.inst_valid_o !== 1'b0) begin bad++; $display("FAIL rmid_empty%0d got=%b want=0", k, bus.inst_valid_o); end
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_single();
        test_exception();
        test_interrupt();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_full_push_pop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
